// File: rtl/task_dispatcher.sv
// task_dispatcher: pops task IDs from the task queue head, stages one task,
// and issues it to a free worker chosen round-robin. Tracks per-worker busy
// state and frees workers that stay busy too long, flagging a sticky error.
module task_dispatcher #(
    parameter int NUM_WORKERS = 4,
    parameter int WID_WIDTH   = 2,
    parameter int TIMEOUT     = 200,
    parameter int TO_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   q_empty,
    input  logic [7:0]             q_task,
    output logic                   q_pop,
    output logic [NUM_WORKERS-1:0] w_start,
    output logic [7:0]             w_task,
    input  logic [NUM_WORKERS-1:0] w_done,
    output logic [NUM_WORKERS-1:0] busy,
    output logic [NUM_WORKERS-1:0] err_timeout,
    input  logic                   err_clr,
    output logic [15:0]            dispatch_count,
    output logic                   idle
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Counter value on the last cycle a worker may remain busy.
    localparam logic [TO_WIDTH-1:0]    TO_LAST     = TO_WIDTH'(TIMEOUT - 1);
    localparam logic [NUM_WORKERS-1:0] ONE_HOT_LSB = {{(NUM_WORKERS-1){1'b0}}, 1'b1};

    // Worker index reached by stepping 'step' places past 'base', wrapping.
    function automatic logic [WID_WIDTH-1:0] f_wrap_idx(input int base, input int step);
        f_wrap_idx = WID_WIDTH'((base + step) % NUM_WORKERS);
    endfunction

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [7:0]               r_hold_task;
    logic [WID_WIDTH-1:0]     r_rr_ptr;
    logic [NUM_WORKERS-1:0]   r_busy;
    logic [NUM_WORKERS-1:0]   r_err;
    logic [NUM_WORKERS-1:0]   r_start;
    logic [7:0]               r_task_out;
    logic [15:0]              r_count;
    logic [TO_WIDTH-1:0]      r_to_cnt [NUM_WORKERS];

    logic                     w_pop;
    logic                     w_fire;
    logic                     w_grant_found;
    logic [WID_WIDTH-1:0]     w_grant_idx;
    logic [NUM_WORKERS-1:0]   w_grant_vec;
    logic [NUM_WORKERS-1:0]   w_timeout_hit;

    // State register: IDLE means the staging register is empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Round-robin search for the first free worker after the last grant.
    // Uses the registered busy vector, so a worker finishing this cycle waits.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 1; k <= NUM_WORKERS; k++) begin
            if (!w_grant_found && !r_busy[f_wrap_idx(int'(r_rr_ptr), k)]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = f_wrap_idx(int'(r_rr_ptr), k);
            end else begin
                w_grant_found = w_grant_found;
                w_grant_idx   = w_grant_idx;
            end
        end
    end

    // Next-state logic: fill staging from the queue, drain it into a worker.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (w_grant_found) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State outputs: pop only when staging is empty; dispatch only when holding.
    // The pop is held off during reset so no queue entry is lost to a reset edge.
    always_comb begin
        w_pop  = 1'b0;
        w_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pop  = rst_n & enable & ~q_empty;
                w_fire = 1'b0;
            end
            ST_HOLD: begin
                w_pop  = 1'b0;
                w_fire = w_grant_found;
            end
            default: begin
                w_pop  = 1'b0;
                w_fire = 1'b0;
            end
        endcase
    end

    // One-hot grant vector and per-worker timeout detection (done wins).
    always_comb begin
        if (w_fire) begin
            w_grant_vec = ONE_HOT_LSB << w_grant_idx;
        end else begin
            w_grant_vec = '0;
        end
        for (int i = 0; i < NUM_WORKERS; i++) begin
            w_timeout_hit[i] = r_busy[i] & ~w_done[i] & (r_to_cnt[i] == TO_LAST);
        end
    end

    // Staging register captures the queue head on a pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_task <= 8'h00;
        end else if (w_pop) begin
            r_hold_task <= q_task;
        end else begin
            r_hold_task <= r_hold_task;
        end
    end

    // Dispatch: single-cycle start pulse, task ID, round-robin pointer, count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start    <= '0;
            r_task_out <= 8'h00;
            r_rr_ptr   <= WID_WIDTH'(NUM_WORKERS - 1);
            r_count    <= 16'h0000;
        end else begin
            r_start <= w_grant_vec;
            if (w_fire) begin
                r_task_out <= r_hold_task;
                r_rr_ptr   <= w_grant_idx;
                r_count    <= r_count + 16'd1;
            end else begin
                r_task_out <= r_task_out;
                r_rr_ptr   <= r_rr_ptr;
                r_count    <= r_count;
            end
        end
    end

    // Per-worker busy flags and timeout counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
            for (int i = 0; i < NUM_WORKERS; i++) begin
                r_to_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WORKERS; i++) begin
                if (w_grant_vec[i]) begin
                    r_busy[i]   <= 1'b1;
                    r_to_cnt[i] <= '0;
                end else if (r_busy[i]) begin
                    if (w_done[i] || w_timeout_hit[i]) begin
                        r_busy[i]   <= 1'b0;
                        r_to_cnt[i] <= '0;
                    end else begin
                        r_to_cnt[i] <= r_to_cnt[i] + {{(TO_WIDTH-1){1'b0}}, 1'b1};
                    end
                end else begin
                    r_to_cnt[i] <= '0;
                end
            end
        end
    end

    // Sticky timeout flags; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= '0;
        end else if (err_clr) begin
            r_err <= w_timeout_hit;
        end else begin
            r_err <= r_err | w_timeout_hit;
        end
    end

    assign q_pop          = w_pop;
    assign w_start        = r_start;
    assign w_task         = r_task_out;
    assign busy           = r_busy;
    assign err_timeout    = r_err;
    assign dispatch_count = r_count;
    assign idle           = (r_state == ST_IDLE) && (r_busy == '0);

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher. Instance A runs the default timeout and
// exercises dispatch order, stalls, round-robin, enable and reset; instance B
// uses a 5-cycle timeout for the timeout and error-clear behaviour.
module tb_task_dispatcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic        rst_n, enable, q_empty, q_pop, err_clr, idle;
    logic [7:0]  q_task, w_task;
    logic [3:0]  w_start, w_done, busy, err_timeout;
    logic [15:0] dispatch_count;

    // Instance B signals
    logic        b_rst_n, b_enable, b_q_empty, b_q_pop, b_err_clr, b_idle;
    logic [7:0]  b_q_task, b_w_task;
    logic [3:0]  b_w_start, b_w_done, b_busy, b_err_timeout;
    logic [15:0] b_dispatch_count;

    task_dispatcher u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .q_empty(q_empty),
        .q_task(q_task), .q_pop(q_pop), .w_start(w_start), .w_task(w_task),
        .w_done(w_done), .busy(busy), .err_timeout(err_timeout),
        .err_clr(err_clr), .dispatch_count(dispatch_count), .idle(idle)
    );

    task_dispatcher #(.NUM_WORKERS(4), .WID_WIDTH(2), .TIMEOUT(5), .TO_WIDTH(8)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .enable(b_enable), .q_empty(b_q_empty),
        .q_task(b_q_task), .q_pop(b_q_pop), .w_start(b_w_start), .w_task(b_w_task),
        .w_done(b_w_done), .busy(b_busy), .err_timeout(b_err_timeout),
        .err_clr(b_err_clr), .dispatch_count(b_dispatch_count), .idle(b_idle)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int q_head;
    int q_len;
    logic popped;

    // Queue contents seen by instance A, in order.
    localparam logic [7:0] QMEM [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h61,
                                         8'h62, 8'h63, 8'h64, 8'h65, 8'h71, 8'h72};

    // Instance A per-cycle stimulus
    localparam int A_N = 35;
    localparam int A_QLEN [A_N] = '{3,3,3,3,3, 3,3,5,5,5, 5,5,5,5,8, 8,8,8,8,8,
                                     8,9,9,9,10, 10,12,12,12,12, 12,12,12,12,12};
    localparam logic A_EN [A_N] = '{1,1,1,1,1, 1,1,1,1,1, 1,1,1,1,1, 1,1,1,1,1,
                                     1,1,1,1,1, 1,1,0,0,0, 1,1,1,1,1};
    localparam logic A_RST [A_N] = '{1,1,1,1,1, 1,1,1,1,1, 1,1,1,1,1, 1,1,1,1,1,
                                      1,1,1,1,1, 1,1,1,1,1, 1,1,0,1,1};
    localparam logic [3:0] A_DONE [A_N] = '{4'h0,4'h0,4'h0,4'h0,4'h0, 4'h0,4'h0,4'h0,4'h0,4'h0,
                                            4'h0,4'h4,4'h0,4'hB,4'h0, 4'h0,4'h0,4'h0,4'h0,4'h0,
                                            4'h9,4'h0,4'h0,4'h8,4'h0, 4'h0,4'h0,4'h0,4'h0,4'h0,
                                            4'h0,4'hA,4'h0,4'h1,4'h0};
    // Instance A expected outputs
    localparam logic A_POP [A_N] = '{1,0,1,0,1, 0,0,1,0,1, 0,0,0,0,1, 0,1,0,1,0,
                                      0,1,0,0,1, 0,1,0,0,0, 1,0,0,0,0};
    localparam logic [3:0] A_WS [A_N] = '{4'h0,4'h0,4'h1,4'h0,4'h2, 4'h0,4'h4,4'h0,4'h0,4'h8,
                                          4'h0,4'h0,4'h0,4'h4,4'h0, 4'h0,4'h8,4'h0,4'h1,4'h0,
                                          4'h2,4'h0,4'h0,4'h8,4'h0, 4'h0,4'h1,4'h0,4'h8,4'h0,
                                          4'h0,4'h0,4'h0,4'h0,4'h0};
    localparam logic [7:0] A_WT [A_N] = '{8'h00,8'h00,8'h11,8'h11,8'h22, 8'h22,8'h33,8'h33,8'h33,8'h44,
                                          8'h44,8'h44,8'h44,8'h55,8'h55, 8'h55,8'h61,8'h61,8'h62,8'h62,
                                          8'h63,8'h63,8'h63,8'h64,8'h64, 8'h64,8'h65,8'h65,8'h71,8'h71,
                                          8'h71,8'h71,8'h71,8'h00,8'h00};
    localparam logic [3:0] A_BUSY [A_N] = '{4'h0,4'h0,4'h1,4'h1,4'h3, 4'h3,4'h7,4'h7,4'h7,4'hF,
                                            4'hF,4'hF,4'hB,4'hF,4'h4, 4'h4,4'hC,4'hC,4'hD,4'hD,
                                            4'hF,4'h6,4'h6,4'hE,4'h6, 4'h6,4'h7,4'h7,4'hF,4'hF,
                                            4'hF,4'hF,4'h5,4'h0,4'h0};
    localparam int A_CNT [A_N] = '{0,0,1,1,2, 2,3,3,3,4, 4,4,4,5,5, 5,6,6,7,7,
                                    8,8,8,9,9, 9,10,10,11,11, 11,11,11,0,0};
    localparam logic A_IDLE [A_N] = '{1,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,
                                       0,0,0,0,0, 0,0,0,0,0, 0,0,0,1,1};

    // Instance B per-cycle stimulus
    localparam int B_N = 24;
    localparam logic B_QE [B_N] = '{0,1,1,1,1, 1,1,1,0,1, 1,1,1,1,1, 0,1,1,1,1, 1,1,1,1};
    localparam logic [7:0] B_QT [B_N] = '{8'hA5,8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h5A,8'h00,
                                          8'h00,8'h00,8'h00,8'h00,8'h00, 8'h3C,8'h00,8'h00,8'h00,8'h00,
                                          8'h00,8'h00,8'h00,8'h00};
    localparam logic [3:0] B_DONE [B_N] = '{4'h0,4'h0,4'h0,4'h0,4'h0, 4'h0,4'h0,4'h0,4'h0,4'h0,
                                            4'h0,4'h0,4'h0,4'h0,4'h2, 4'h0,4'h0,4'h0,4'h0,4'h0,
                                            4'h0,4'h0,4'h0,4'h0};
    localparam logic B_CLR [B_N] = '{0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,1,1,0};
    // Instance B expected outputs
    localparam logic B_POP [B_N] = '{1,0,0,0,0, 0,0,0,1,0, 0,0,0,0,0, 1,0,0,0,0, 0,0,0,0};
    localparam logic [3:0] B_WS [B_N] = '{4'h0,4'h0,4'h1,4'h0,4'h0, 4'h0,4'h0,4'h0,4'h0,4'h0,
                                          4'h2,4'h0,4'h0,4'h0,4'h0, 4'h0,4'h0,4'h4,4'h0,4'h0,
                                          4'h0,4'h0,4'h0,4'h0};
    localparam logic [7:0] B_WT [B_N] = '{8'h00,8'h00,8'hA5,8'hA5,8'hA5, 8'hA5,8'hA5,8'hA5,8'hA5,8'hA5,
                                          8'h5A,8'h5A,8'h5A,8'h5A,8'h5A, 8'h5A,8'h5A,8'h3C,8'h3C,8'h3C,
                                          8'h3C,8'h3C,8'h3C,8'h3C};
    localparam logic [3:0] B_BUSY [B_N] = '{4'h0,4'h0,4'h1,4'h1,4'h1, 4'h1,4'h1,4'h0,4'h0,4'h0,
                                            4'h2,4'h2,4'h2,4'h2,4'h2, 4'h0,4'h0,4'h4,4'h4,4'h4,
                                            4'h4,4'h4,4'h0,4'h0};
    localparam logic [3:0] B_ERR [B_N] = '{4'h0,4'h0,4'h0,4'h0,4'h0, 4'h0,4'h0,4'h1,4'h1,4'h1,
                                           4'h1,4'h1,4'h1,4'h1,4'h1, 4'h1,4'h1,4'h1,4'h1,4'h1,
                                           4'h1,4'h1,4'h4,4'h0};

    // Count one comparison and report it when observed differs from expected.
    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present the queue head to instance A.
    task automatic drive_queue();
        q_empty = (q_head >= q_len);
        q_task  = q_empty ? 8'h00 : QMEM[q_head];
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; w_done = 4'h0; err_clr = 1'b0;
        q_head = 0; q_len = 3;
        drive_queue();
        b_rst_n = 1'b0; b_enable = 1'b1; b_q_empty = 1'b1; b_q_task = 8'h00;
        b_w_done = 4'h0; b_err_clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        // Reset values; the queue is non-empty so q_pop must be held low.
        chk_eq("rst q_pop",   32'(q_pop), 32'd0);
        chk_eq("rst w_start", 32'(w_start), 32'd0);
        chk_eq("rst w_task",  32'(w_task), 32'd0);
        chk_eq("rst busy",    32'(busy), 32'd0);
        chk_eq("rst err",     32'(err_timeout), 32'd0);
        chk_eq("rst count",   32'(dispatch_count), 32'd0);
        chk_eq("rst idle",    32'(idle), 32'd1);
        chk_eq("rst b_busy",  32'(b_busy), 32'd0);
        chk_eq("rst b_idle",  32'(b_idle), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < A_N; i++) begin
            q_len  = A_QLEN[i];
            drive_queue();
            enable = A_EN[i];
            rst_n  = A_RST[i];
            w_done = A_DONE[i];
            @(negedge clk);
            chk_eq($sformatf("A%0d q_pop", i),   32'(q_pop), 32'(A_POP[i]));
            chk_eq($sformatf("A%0d w_start", i), 32'(w_start), 32'(A_WS[i]));
            chk_eq($sformatf("A%0d w_task", i),  32'(w_task), 32'(A_WT[i]));
            chk_eq($sformatf("A%0d busy", i),    32'(busy), 32'(A_BUSY[i]));
            chk_eq($sformatf("A%0d count", i),   32'(dispatch_count), 32'(A_CNT[i]));
            chk_eq($sformatf("A%0d idle", i),    32'(idle), 32'(A_IDLE[i]));
            chk_eq($sformatf("A%0d err", i),     32'(err_timeout), 32'd0);
            popped = q_pop;
            @(posedge clk);
            #1;
            if (popped) q_head++;
        end
        w_done = 4'h0;

        for (int j = 0; j < B_N; j++) begin
            b_rst_n   = 1'b1;
            b_q_empty = B_QE[j];
            b_q_task  = B_QT[j];
            b_w_done  = B_DONE[j];
            b_err_clr = B_CLR[j];
            @(negedge clk);
            chk_eq($sformatf("B%0d q_pop", j),   32'(b_q_pop), 32'(B_POP[j]));
            chk_eq($sformatf("B%0d w_start", j), 32'(b_w_start), 32'(B_WS[j]));
            chk_eq($sformatf("B%0d w_task", j),  32'(b_w_task), 32'(B_WT[j]));
            chk_eq($sformatf("B%0d busy", j),    32'(b_busy), 32'(B_BUSY[j]));
            chk_eq($sformatf("B%0d err", j),     32'(b_err_timeout), 32'(B_ERR[j]));
            @(posedge clk);
            #1;
        end
        b_w_done = 4'h0;
        b_err_clr = 1'b0;
        @(negedge clk);
        chk_eq("B end count", 32'(b_dispatch_count), 32'd3);
        chk_eq("B end idle",  32'(b_idle), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/task_dispatcher.md
# task_dispatcher

Downstream consumer of the task queue: pops 8-bit task IDs from the queue's head and issues each to one of NUM_WORKERS worker units with a start/done handshake. Holds one task in a staging register, tracks per-worker busy state, selects free workers round-robin, and frees hung workers after a programmable timeout with a sticky error flag. Sits between the task queue and the worker array in the scheduler top level.

## Interface
- NUM_WORKERS, 4: number of worker units, 2..8.
- WID_WIDTH, 2: width of worker index, log2(NUM_WORKERS).
- TIMEOUT, 200: cycles a worker may stay busy before it is forcibly freed, 2..2^TO_WIDTH-1.
- TO_WIDTH, 8: width of per-worker timeout counters.
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- enable  input  1  when low, no new pops; an already staged task is still dispatched.
- q_empty  input  1  queue empty flag.
- q_task  input  8  queue head task, valid when q_empty low.
- q_pop  output  1  dequeue strobe to queue (combinational).
- w_start  output  NUM_WORKERS  one-hot, one-cycle start pulse (registered).
- w_task  output  8  task ID for the worker pulsed in w_start (registered).
- w_done  input  NUM_WORKERS  per-worker one-cycle completion pulse.
- busy  output  NUM_WORKERS  registered per-worker busy flags.
- err_timeout  output  NUM_WORKERS  sticky per-worker timeout flags.
- err_clr  input  1  clears all err_timeout bits.
- dispatch_count  output  16  tasks dispatched, wraps at 2^16.
- idle  output  1  state IDLE and busy all zero.

## Operation
- States: IDLE (staging empty), HOLD (staging holds a task).
- IDLE: q_pop = enable && !q_empty; on that edge hold_task <= q_task, go HOLD. Otherwise stay.
- HOLD: q_pop = 0. If any busy bit is 0, grant = first free index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_WORKERS; on that edge w_start[grant] <= 1, w_task <= hold_task, busy[grant] <= 1, rr_ptr <= grant, dispatch_count += 1, go IDLE. No free worker: stay HOLD, hold_task unchanged.
- w_start is a single-cycle pulse; cleared the following cycle. w_task holds its last value between pulses.
- Free-worker test uses the registered busy vector: a worker whose w_done arrives in the grant cycle is not eligible that cycle.
- w_done[i] with busy[i]=1: busy[i] <= 0 next edge. w_done[i] with busy[i]=0: ignored.
- Timeout: per-worker counter cleared on grant, increments each cycle busy[i]=1. When counter reaches TIMEOUT-1 and w_done[i]=0: busy[i] <= 0, err_timeout[i] <= 1. w_done on that same cycle wins: no error.
- err_clr clears all err_timeout bits; a timeout occurring in the same cycle as err_clr sets its bit (set wins).
- enable only gates q_pop; it does not affect HOLD dispatch, done handling or timeouts.

## Timing
- Reset (rst_n low at a clock edge): state IDLE, q_pop 0, w_start 0, w_task 0, busy 0, err_timeout 0, dispatch_count 0, rr_ptr = NUM_WORKERS-1 (first grant goes to worker 0), timeout counters 0, idle 1. Reset mid-HOLD discards the staged task; a worker that was busy is freed and its later w_done is ignored.
- Latency: q_pop high in cycle N -> w_start high in cycle N+2 if a worker is free at edge N+1.
- Peak throughput: one task per 2 cycles.
- busy[i] rises the same edge w_start[i] rises; falls the edge after w_done[i].
- Timeout fires exactly TIMEOUT cycles after the w_start edge when no done arrives.

## Test plan
- Reset, queue holds 0x11,0x22,0x33, all workers free -> q_pop in cycles 1,3,5; w_start = 0001,0010,0100 with w_task 0x11,0x22,0x33; dispatch_count = 3.
- All 4 workers busy, queue non-empty -> one pop then HOLD, q_pop stays 0; pulse w_done[2] -> next grant to worker 2 two edges later, busy = 1111 again.
- Round-robin: rr_ptr = 1, workers 0 and 3 free -> grant worker 3; next free test with 0 and 3 free -> grant 0.
- TIMEOUT=5, no done on worker 0 -> busy[0] clears and err_timeout[0]=1 five cycles after start; w_done[0] at cycle 5 instead -> no error; err_clr -> err_timeout=0.
- enable=0 with queue non-empty and task staged -> staged task dispatched, no further q_pop until enable=1.
- rst_n low during HOLD with busy=0101 -> all outputs at reset values next cycle; stray w_done[0] afterwards leaves busy=0000.
